fmap_collector: RTL and testbench
=================================

Name: fmap_collector

Overview:
- Receiving end of the accelerator's output feature-map stream (addr/data/valid element writes, no backpressure).
- Assembles one complete NUM_ELEMS-element feature map into a double-buffered RAM.
- Replays each completed map, in ascending address order, on a valid/ready stream toward the host/DMA side.
- Drops and counts whole frames when the readout side is still busy.

Parameters:
ADDR_BITS, 6, width of element address
DATA_BITS, 8, width of element data
NUM_ELEMS, 64, elements per feature map (must be <= 2^ADDR_BITS)
CNT_BITS, 16, width of frame/drop counters

Ports:
clk  input  1  system clock (200 MHz)
reset  input  1  asynchronous, active-low reset
in_addr  input  ADDR_BITS  incoming feature-map element address
in_data  input  DATA_BITS  incoming feature-map element data
in_valid  input  1  element write strobe; no ready, must be accepted every cycle
m_addr  output  ADDR_BITS  address of streamed element
m_data  output  DATA_BITS  streamed element data
m_valid  output  1  stream valid
m_ready  input  1  stream ready from consumer
m_last  output  1  high with element NUM_ELEMS-1 of a frame
frame_count  output  CNT_BITS  frames handed to readout, saturating
drop_count  output  CNT_BITS  frames discarded due to busy readout, saturating
busy  output  1  readout bank holds an unsent/partially sent frame

Behaviour:
- Reset (async assert, sync release) clears:
  - outputs: m_valid, m_last, m_addr, m_data, frame_count, drop_count, busy all 0;
  - internal state: write-bank select = 0, element mask = 0, read FSM = IDLE.
  - RAM contents are not cleared.
- Write side:
  - On in_valid with in_addr < NUM_ELEMS: write mem[wbank][in_addr] <= in_data and set mask[in_addr].
  - in_addr >= NUM_ELEMS is ignored entirely.
  - Duplicate addresses overwrite silently; the mask bit stays set.
- Frame complete = mask (including the current cycle's write) is all ones. In that same cycle:
  - If readout is free: swap banks (rbank <= wbank, wbank toggles), clear mask, increment frame_count (saturating), start readout.
  - Otherwise: clear mask, keep wbank (the next frame overwrites it), increment drop_count (saturating).
  - Readout is "free" when the FSM is IDLE, or when the FSM is STREAM with an m_last handshake (m_valid & m_ready & m_last) in that same cycle.
- Read FSM:
  - IDLE:
    - On start -> FETCH with rd_ptr = 0.
    - busy goes to 1 in the cycle after start.
  - FETCH:
    - One-cycle synchronous RAM read of mem[rbank][rd_ptr] -> STREAM.
    - In STREAM, m_valid = 1, m_addr = rd_ptr, m_data = RAM output, m_last = (rd_ptr == NUM_ELEMS-1).
  - STREAM:
    - Outputs stay stable while m_valid & !m_ready.
    - On handshake with !m_last: rd_ptr++ and the next word is presented; the pipeline (read ahead or skid) must sustain one element per cycle under continuous m_ready, with no bubbles between elements.
    - On handshake with m_last: if a start occurs in the same cycle -> FETCH at rd_ptr 0 on the new bank (busy stays 1); else -> IDLE, m_valid and busy drop next cycle.
- Latency:
  - The write completing a frame is at cycle T; m_valid first asserts at T+2 (T+1 is IDLE->FETCH; RAM data is registered at T+2).
  - With m_ready held high, a frame drains in NUM_ELEMS cycles.
- Read/write are on different banks, so there is no read/write collision.
- m_valid is never retracted before its handshake.
- Counters hold at all-ones.

Test Plan:
- Write addrs 0..63 in order, data = addr^0xA5, m_ready=1 -> m_valid rises 2 cycles after write 63; 64 consecutive beats addr 0..63, data matches, m_last only on addr 63; frame_count=1, busy returns to 0.
- Write addrs 63..0 reversed with a duplicate write to addr 5 (first 0x11, then 0x22) -> exactly one frame fires after all 64 covered; readout addr 5 = 0x22.
- m_ready toggled pseudo-randomly during readout -> no data changes while stalled, no lost or duplicated beats, order 0..63 preserved.
- Hold m_ready=0, complete two further frames -> first is readout, second increments drop_count to 1, frame_count unchanged; releasing m_ready yields the first frame's data intact.
- Complete a new frame in the exact cycle of the m_last handshake -> frame accepted (frame_count+1, drop_count unchanged), next frame starts without IDLE gap in busy.
- Assert reset (low) mid-stream at beat 30 -> m_valid, busy, counters to 0 asynchronously; after release, a fresh 64-element write produces a full correct frame starting at addr 0; addr 64+ writes (ADDR_BITS=7 build) are ignored.

Source files
------------

// File: rtl/fmap_collector.sv
// -----------------------------------------------------------------------------
// fmap_collector
//
// Receiving end of the accelerator's output feature-map stream. Element writes
// (addr/data/valid, no backpressure) are assembled into one bank of a
// double-buffered RAM. Once every element of a map has been written at least
// once, the map is handed to the readout side. The readout side replays it in
// ascending address order on a valid/ready stream. If the readout bank is
// still occupied when a new map completes, that new map is discarded and
// counted.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   in_addr      incoming element address (addresses >= NUM_ELEMS are ignored)
//   in_data      incoming element data
//   in_valid     element write strobe, accepted every cycle
//   m_addr       address of the streamed element
//   m_data       streamed element data
//   m_valid      stream valid
//   m_ready      stream ready from the consumer
//   m_last       high with element NUM_ELEMS-1 of a frame
//   frame_count  frames handed to readout (saturating)
//   drop_count   frames discarded because readout was busy (saturating)
//   busy         readout bank holds an unsent or partially sent frame
// -----------------------------------------------------------------------------
module fmap_collector #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 8,
  parameter int NUM_ELEMS = 64,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [CNT_BITS-1:0]  frame_count,
  output logic [CNT_BITS-1:0]  drop_count,
  output logic                 busy
);

  // Each bank spans the full address space so any in-range address indexes it
  // directly; only the first NUM_ELEMS words are ever written.
  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [2][DEPTH];
  logic                 wbank;
  logic                 rbank;
  logic [NUM_ELEMS-1:0] mask;
  logic [NUM_ELEMS-1:0] mask_set;
  logic [NUM_ELEMS-1:0] mask_next;
  logic                 wr_hit;
  logic                 frame_done;
  logic                 last_hs;
  logic                 rd_free;
  logic                 start;
  logic [ADDR_BITS-1:0] next_addr;

  // ---------------------------------------------------------------------------
  // Write-side decode. The one-hot compare against every legal index doubles
  // as the range check: an address >= NUM_ELEMS matches nothing, so it neither
  // writes the RAM nor touches the mask.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    mask_set = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (in_valid && (in_addr == ADDR_BITS'(i))) mask_set[i] = 1'b1;
    end
  end

  always_comb begin
    wr_hit     = |mask_set;
    mask_next  = mask | mask_set;
    frame_done = wr_hit && (&mask_next);
    // The final beat leaving in this very cycle frees the readout bank, so a
    // frame completing at that moment is accepted rather than dropped.
    last_hs    = (state == S_STREAM) && m_valid && m_ready && m_last;
    rd_free    = (state == S_IDLE) || last_hs;
    start      = frame_done && rd_free;
    next_addr  = m_addr + ADDR_BITS'(1);
  end

  // ---------------------------------------------------------------------------
  // Frame storage. Write and read always target opposite banks, so there is
  // no collision to arbitrate.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array is deliberately left out of reset; resetting it would
  // turn the memory into a huge register file. Its contents are only consumed
  // after a full frame has been written.
  always_ff @(posedge clk) begin
    if (wr_hit) mem[wbank][in_addr] <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Frame assembly, bank swap and counters.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      mask        <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      mask <= frame_done ? '0 : mask_next;
      if (start) begin
        rbank <= wbank;
        wbank <= ~wbank;
        if (frame_count != '1) frame_count <= frame_count + CNT_BITS'(1);
      end else if (frame_done) begin
        // Readout still busy: keep the write bank so the next frame simply
        // overwrites the discarded one.
        if (drop_count != '1) drop_count <= drop_count + CNT_BITS'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. m_addr doubles as the read pointer. The RAM read is synchronous
  // into the m_data register: FETCH primes element 0, and in STREAM each
  // accepted beat reads the following element in the same edge, which keeps
  // one element per cycle under continuous m_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          m_addr  <= '0;
          m_data  <= mem[rbank][0];
          m_last  <= (LAST_ADDR == '0);
          m_valid <= 1'b1;
          state   <= S_STREAM;
        end

        S_STREAM: begin
          if (m_valid && m_ready) begin
            if (!m_last) begin
              m_addr <= next_addr;
              m_data <= mem[rbank][next_addr];
              m_last <= (next_addr == LAST_ADDR);
            end else if (start) begin
              // Back-to-back frame: rbank has just been swapped, go straight
              // to fetching the new bank and keep busy asserted.
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= S_FETCH;
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_collector.sv
// -----------------------------------------------------------------------------
// tb_fmap_collector
//
// Directed bench for fmap_collector, built with ADDR_BITS=7 so that addresses
// at and above NUM_ELEMS can be driven. A negedge monitor records every
// accepted stream beat (address, data, last flag, cycle) and counts any change
// of the presented beat while it is stalled. Each test task drives its own
// stimulus and compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fmap_collector;

  localparam int AB = 7;
  localparam int DB = 8;
  localparam int NE = 64;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AB-1:0] in_addr = '0;
  logic [DB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [AB-1:0] m_addr;
  logic [DB-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [CB-1:0] frame_count;
  logic [CB-1:0] drop_count;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  fmap_collector #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .NUM_ELEMS(NE),
    .CNT_BITS (CB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_count(frame_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stream monitor
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  logic [AB-1:0] beat_addr [$];
  logic [DB-1:0] beat_data [$];
  logic          beat_last [$];
  int            beat_cyc  [$];
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [AB-1:0] prev_addr;
  logic [DB-1:0] prev_data;
  logic          prev_last;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        if (m_valid !== 1'b1 || m_addr !== prev_addr || m_data !== prev_data ||
            m_last !== prev_last)
          stall_err++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        beat_addr.push_back(m_addr);
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(cyc);
      end
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_addr  = m_addr;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input logic [AB-1:0] a, input logic [DB-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_beats();
    beat_addr.delete();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (beat_addr.size() < n && k < budget) begin
      tick();
      k++;
    end
    vectors++;
    if (beat_addr.size() < n) begin
      miscompares++;
      $display("FAIL %s: only %0d beats after %0d cycles, required %0d", name,
               beat_addr.size(), budget, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_addr !== '0 || m_data !== '0 ||
        frame_count !== '0 || drop_count !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b last=%0b addr=%0d data=%02h fc=%0d dc=%0d busy=%0b, required all 0",
               m_valid, m_last, m_addr, m_data, frame_count, drop_count, busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    logic [DB-1:0] exp_d [NE];
    clear_beats();
    m_ready = 1'b1;
    for (int i = 0; i < NE; i++) begin
      exp_d[i] = DB'(i) ^ 8'hA5;
      write_elem(AB'(i), exp_d[i]);
    end
    // One edge after the completing write: FETCH, busy already up.
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL inorder_t1: m_valid=%0b busy=%0b, required 0/1", m_valid, busy);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b1 || m_addr !== '0 || m_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL inorder_t2: m_valid=%0b addr=%0d data=%02h, required 1/0/a5",
               m_valid, m_addr, m_data);
    end
    wait_beats(NE, 200, "inorder_drain");
    for (int i = 0; i < NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i) || beat_data[i] !== exp_d[i] ||
          beat_last[i] !== (i == NE - 1)) begin
        miscompares++;
        $display("FAIL inorder_beat%0d: addr=%0d data=%02h last=%0b, required %0d/%02h/%0b",
                 i, beat_addr[i], beat_data[i], beat_last[i], i, exp_d[i], (i == NE - 1));
      end
    end
    vectors++;
    if (beat_cyc.size() >= NE && beat_cyc[NE-1] - beat_cyc[0] != NE - 1) begin
      miscompares++;
      $display("FAIL inorder_bubbles: frame spanned %0d cycles, required %0d",
               beat_cyc[NE-1] - beat_cyc[0] + 1, NE);
    end
    vectors++;
    if (frame_count !== 16'd1 || drop_count !== 16'd0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inorder_end: fc=%0d dc=%0d busy=%0b valid=%0b, required 1/0/0/0",
               frame_count, drop_count, busy, m_valid);
    end
  endtask

  task automatic test_reverse_dup();
    logic [DB-1:0] exp_d [NE];
    clear_beats();
    m_ready = 1'b1;
    for (int i = 0; i < NE; i++) exp_d[i] = DB'(i) ^ 8'h3C;
    exp_d[5] = 8'h22;
    for (int i = NE - 1; i >= 6; i--) write_elem(AB'(i), exp_d[i]);
    write_elem(AB'(5), 8'h11);
    write_elem(AB'(5), 8'h22);
    for (int i = 4; i >= 1; i--) write_elem(AB'(i), exp_d[i]);
    vectors++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL revdup_early: fc=%0d busy=%0b with addr 0 unwritten, required 1/0",
               frame_count, busy);
    end
    write_elem(AB'(0), exp_d[0]);
    wait_beats(NE, 200, "revdup_drain");
    for (int i = 0; i < NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i) || beat_data[i] !== exp_d[i]) begin
        miscompares++;
        $display("FAIL revdup_beat%0d: addr=%0d data=%02h, required %0d/%02h",
                 i, beat_addr[i], beat_data[i], i, exp_d[i]);
      end
    end
    repeat (3) tick();
    vectors++;
    if (frame_count !== 16'd2 || beat_addr.size() != NE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL revdup_count: fc=%0d beats=%0d busy=%0b, required 2/%0d/0",
               frame_count, beat_addr.size(), busy, NE);
    end
  endtask

  task automatic test_stall_random();
    logic [DB-1:0] exp_d [NE];
    int            k;
    int            err0;
    clear_beats();
    err0    = stall_err;
    m_ready = 1'b0;
    for (int i = 0; i < NE; i++) begin
      exp_d[i] = DB'(i * 3 + 7);
      write_elem(AB'(i), exp_d[i]);
    end
    k = 0;
    while (beat_addr.size() < NE && k < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    m_ready = 1'b1;
    vectors++;
    if (beat_addr.size() != NE) begin
      miscompares++;
      $display("FAIL stall_beats: got %0d beats, required %0d", beat_addr.size(), NE);
    end
    for (int i = 0; i < NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i) || beat_data[i] !== exp_d[i] ||
          beat_last[i] !== (i == NE - 1)) begin
        miscompares++;
        $display("FAIL stall_beat%0d: addr=%0d data=%02h last=%0b, required %0d/%02h/%0b",
                 i, beat_addr[i], beat_data[i], beat_last[i], i, exp_d[i], (i == NE - 1));
      end
    end
    repeat (2) tick();
    vectors++;
    if (stall_err != err0 || frame_count !== 16'd3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: stall changes=%0d fc=%0d busy=%0b, required 0/3/0",
               stall_err - err0, frame_count, busy);
    end
  endtask

  task automatic test_drop();
    logic [DB-1:0] exp_d [NE];
    int            err0;
    clear_beats();
    err0    = stall_err;
    m_ready = 1'b0;
    for (int i = 0; i < NE; i++) begin
      exp_d[i] = DB'(i) ^ 8'h5A;
      write_elem(AB'(i), exp_d[i]);
    end
    vectors++;
    if (frame_count !== 16'd4 || drop_count !== 16'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_first: fc=%0d dc=%0d busy=%0b, required 4/0/1",
               frame_count, drop_count, busy);
    end
    for (int i = 0; i < NE; i++) write_elem(AB'(i), ~DB'(i));
    vectors++;
    if (frame_count !== 16'd4 || drop_count !== 16'd1 || m_valid !== 1'b1 || m_addr !== '0) begin
      miscompares++;
      $display("FAIL drop_second: fc=%0d dc=%0d valid=%0b addr=%0d, required 4/1/1/0",
               frame_count, drop_count, m_valid, m_addr);
    end
    m_ready = 1'b1;
    wait_beats(NE, 200, "drop_drain");
    for (int i = 0; i < NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i) || beat_data[i] !== exp_d[i]) begin
        miscompares++;
        $display("FAIL drop_beat%0d: addr=%0d data=%02h, required %0d/%02h",
                 i, beat_addr[i], beat_data[i], i, exp_d[i]);
      end
    end
    tick();
    vectors++;
    if (stall_err != err0 || busy !== 1'b0 || frame_count !== 16'd4 || drop_count !== 16'd1) begin
      miscompares++;
      $display("FAIL drop_end: stall changes=%0d busy=%0b fc=%0d dc=%0d, required 0/0/4/1",
               stall_err - err0, busy, frame_count, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] exp_c [NE];
    logic [DB-1:0] exp_d [NE];
    int            k;
    clear_beats();
    m_ready = 1'b0;
    for (int i = 0; i < NE; i++) begin
      exp_c[i] = DB'(i) ^ 8'hC3;
      exp_d[i] = DB'(i) ^ 8'h96;
      write_elem(AB'(i), exp_c[i]);
    end
    // Frame D minus its last element while C sits stalled at beat 0.
    for (int i = 0; i < NE - 1; i++) write_elem(AB'(i), exp_d[i]);
    m_ready = 1'b1;
    k = 0;
    while (!(m_valid === 1'b1 && m_addr === AB'(NE - 1)) && k < 200) begin
      tick();
      k++;
    end
    vectors++;
    if (m_valid !== 1'b1 || m_addr !== AB'(NE - 1) || m_last !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reach_last: valid=%0b addr=%0d last=%0b, required 1/%0d/1",
               m_valid, m_addr, m_last, NE - 1);
    end
    // The completing write lands on the same edge as C's m_last handshake.
    write_elem(AB'(NE - 1), exp_d[NE-1]);
    vectors++;
    if (frame_count !== 16'd6 || drop_count !== 16'd1 || busy !== 1'b1 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: fc=%0d dc=%0d busy=%0b valid=%0b, required 6/1/1/0",
               frame_count, drop_count, busy, m_valid);
    end
    tick();
    vectors++;
    if (busy !== 1'b1 || m_valid !== 1'b1 || m_addr !== '0 || m_data !== exp_d[0]) begin
      miscompares++;
      $display("FAIL b2b_restart: busy=%0b valid=%0b addr=%0d data=%02h, required 1/1/0/%02h",
               busy, m_valid, m_addr, m_data, exp_d[0]);
    end
    wait_beats(2 * NE, 200, "b2b_drain");
    for (int i = 0; i < 2 * NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i % NE) ||
          beat_data[i] !== ((i < NE) ? exp_c[i % NE] : exp_d[i % NE])) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: addr=%0d data=%02h, required %0d/%02h", i,
                 beat_addr[i], beat_data[i], i % NE,
                 (i < NE) ? exp_c[i % NE] : exp_d[i % NE]);
      end
    end
    vectors++;
    if (beat_cyc.size() >= 2 * NE && beat_cyc[NE] - beat_cyc[NE-1] != 2) begin
      miscompares++;
      $display("FAIL b2b_gap: %0d cycles between frames, required 2",
               beat_cyc[NE] - beat_cyc[NE-1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] exp_d [NE];
    clear_beats();
    m_ready = 1'b1;
    for (int i = 0; i < NE; i++) write_elem(AB'(i), DB'(i) ^ 8'h0F);
    wait_beats(30, 200, "rstmid_reach30");
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || frame_count !== '0 || drop_count !== '0 ||
        m_last !== 1'b0 || m_addr !== '0 || m_data !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: valid=%0b busy=%0b fc=%0d dc=%0d last=%0b addr=%0d data=%02h, required all 0",
               m_valid, busy, frame_count, drop_count, m_last, m_addr, m_data);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    clear_beats();
    for (int i = 0; i < NE; i++) exp_d[i] = DB'(i) ^ 8'h5F;
    for (int i = 0; i < NE - 1; i++) write_elem(AB'(i), exp_d[i]);
    write_elem(AB'(64), 8'hEE);
    write_elem(AB'(100), 8'hEE);
    write_elem(AB'(127), 8'hEE);
    repeat (3) tick();
    vectors++;
    if (frame_count !== '0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_oor: fc=%0d busy=%0b valid=%0b after out-of-range writes, required 0/0/0",
               frame_count, busy, m_valid);
    end
    write_elem(AB'(NE - 1), exp_d[NE-1]);
    wait_beats(NE, 200, "rstmid_drain");
    for (int i = 0; i < NE && i < beat_addr.size(); i++) begin
      vectors++;
      if (beat_addr[i] !== AB'(i) || beat_data[i] !== exp_d[i] ||
          beat_last[i] !== (i == NE - 1)) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d: addr=%0d data=%02h last=%0b, required %0d/%02h/%0b",
                 i, beat_addr[i], beat_data[i], beat_last[i], i, exp_d[i], (i == NE - 1));
      end
    end
    tick();
    vectors++;
    if (frame_count !== 16'd1 || drop_count !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_end: fc=%0d dc=%0d busy=%0b, required 1/0/0",
               frame_count, drop_count, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_in_order();
    test_reverse_dup();
    test_stall_random();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
